sram_xfer_controller: RTL and testbench
=======================================

Name: sram_xfer_controller

Overview:
- Parametrised address/enable sequencer for the AES SRAM ports; successor to the fixed 8-bit read/write address generator.
- Handles one transfer per start pulse in read-only, write-only or read-then-write mode, with programmable base addresses and length.
- Supports an SRAM stall input and a write-permission gate (generalised key-ready flag).
- Sits between the top-level AES control FSM and the SRAM wrapper.

Parameters:
- ADDR_W, 8: address and length width in bits.
- LEN_MAX, 255: largest accepted len. A larger len is clamped to LEN_MAX at capture.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous and active-low.
- start  in  1  request pulse. Sampled only in IDLE.
- mode  in  2  transfer mode: 00 none, 01 read, 10 write, 11 read-then-write. Captured on start.
- s_addr  in  ADDR_W  read base address. Captured on start.
- d_addr  in  ADDR_W  write base address. Captured on start.
- len  in  ADDR_W  word count per phase. Captured on start.
- wr_gate  in  1  write permission (e.g. round keys ready). Low stalls the write phase.
- stall  in  1  SRAM busy. Holds the current address and suppresses enables.
- r_en  out  1  SRAM read enable.
- w_en  out  1  SRAM write enable.
- r_addr  out  ADDR_W  read address.
- w_addr  out  ADDR_W  write address.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE; all captured registers and cnt cleared; r_en, w_en, busy, done are 0; r_addr and w_addr are 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - start=1 captures mode, s_addr, d_addr and len (clamped to LEN_MAX), and clears cnt.
  - Next state: len==0 or mode==00 -> DONE; mode 01 or 11 -> RD; mode 10 -> WR.
- RD:
  - r_en = !stall.
  - r_addr = s_addr_q + cnt, modulo 2^ADDR_W (wraps 0xFF -> 0x00 at ADDR_W=8).
  - cnt increments only on cycles where r_en=1.
  - When a read issues with cnt==len_q-1: mode 11 -> WR with cnt cleared; mode 01 -> DONE.
- WR:
  - w_en = wr_gate && !stall.
  - w_addr = d_addr_q + cnt, modulo 2^ADDR_W.
  - cnt increments only on cycles where w_en=1.
  - The last write goes to DONE.
- DONE: done=1 for one cycle, then IDLE. start in DONE is ignored.
- Outputs in other states:
  - r_en=0 outside RD; w_en=0 outside WR.
  - r_addr and w_addr hold their last driven value outside their own phase.
- Latency (no stalls): start sampled at edge 0.
  - Reads issue on cycles 1..len.
  - For mode 11, writes issue on cycles len+1..2*len.
  - done is asserted the cycle after the last access.
- Simultaneous stall and wr_gate=0: no access, cnt holds.
- start while busy: ignored. No queuing, no error.
- Reset mid-transfer: transfer aborted immediately. No done pulse. The next start begins cleanly.

Optional Feature:
- Macro SRAM_XFER_PERF_EN.
- Defined:
  - Adds output stall_cycles [15:0].
  - Cleared on an accepted start and on reset.
  - Increments on every RD/WR cycle where the enable is suppressed (stall, or wr_gate low in WR).
  - Saturates at 0xFFFF; value holds after DONE.
- Undefined: port and counter absent. Functional behaviour is otherwise identical.

Test Plan:
- mode=01, s_addr=0x10, len=4, no stall -> r_en high on cycles 1-4 with r_addr 0x10,0x11,0x12,0x13; done on cycle 5; w_en never high.
- mode=11, s_addr=0xFE, d_addr=0x40, len=3 -> r_addr 0xFE,0xFF,0x00 (wrap); then w_addr 0x40,0x41,0x42 on cycles 4-6; done on cycle 7.
- mode=10, d_addr=0x20, len=2, wr_gate low for cycles 1-3 then high -> w_en only on cycles 4-5 (0x20,0x21); done on cycle 6; stall_cycles=3 with PERF_EN.
- mode=01, len=3, stall high on cycle 2 -> r_addr 0x00 on cycle 1, held with r_en=0 on cycle 2, 0x01/0x02 on cycles 3-4; done on cycle 5.
- len=0 (any mode) -> done on cycle 1, no enables; a second start during RD is ignored (single done pulse).
- n_rst asserted mid-RD (cnt=2 of 5) -> immediate IDLE, r_en=0, no done; a new start with len=1 completes normally.

Source files
------------

// File: rtl/sram_xfer_controller.sv
// Address/enable sequencer for the AES SRAM ports: one read, write or read-then-write transfer per start.
// Define SRAM_XFER_PERF_EN to add the stall_cycles performance counter output.
module sram_xfer_controller #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LEN_MAX = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              wr_gate,
  input  logic              stall,
  output logic              r_en,
  output logic              w_en,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              busy,
`ifdef SRAM_XFER_PERF_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic              done
);

  localparam int unsigned PERF_W = 16;
  localparam logic [1:0]  MODE_NONE = 2'b00;
  localparam logic [1:0]  MODE_RW   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [ADDR_W-1:0]   d_addr_q, d_addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;

  logic [ADDR_W-1:0]   len_cl;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic                rd_fire;
  logic                wr_fire;
  logic                last_beat;
  logic                accept;

  assign len_cl    = (32'(len) > LEN_MAX) ? ADDR_W'(LEN_MAX) : len;
  assign rd_addr   = s_addr_q + cnt_q;
  assign wr_addr   = d_addr_q + cnt_q;
  assign rd_fire   = (state_q == S_RD) && !stall;
  assign wr_fire   = (state_q == S_WR) && wr_gate && !stall;
  assign last_beat = (cnt_q == len_q - ADDR_W'(1));
  assign accept    = (state_q == S_IDLE) && start;

  // State and captured-transfer registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      s_addr_q <= '0;
      d_addr_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      r_addr_q <= '0;
      w_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      s_addr_q <= s_addr_d;
      d_addr_q <= d_addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    s_addr_d = s_addr_q;
    d_addr_d = d_addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    r_addr_d = r_addr_q;
    w_addr_d = w_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          s_addr_d = s_addr;
          d_addr_d = d_addr;
          len_d    = len_cl;
          cnt_d    = '0;
          if ((len_cl == '0) || (mode == MODE_NONE)) begin
            state_d = S_DONE;
          end else if (mode[0]) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        r_addr_d = rd_addr;
        if (rd_fire) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (last_beat) begin
            if (mode_q == MODE_RW) begin
              state_d = S_WR;
              cnt_d   = '0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_WR: begin
        w_addr_d = wr_addr;
        if (wr_fire) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM strobes follow stall/wr_gate in the same cycle; addresses hold outside their phase
  always_comb begin
    r_en   = 1'b0;
    w_en   = 1'b0;
    r_addr = r_addr_q;
    w_addr = w_addr_q;
    busy   = (state_q != S_IDLE);
    done   = 1'b0;
    unique case (state_q)
      S_RD: begin
        r_en   = rd_fire;
        r_addr = rd_addr;
      end
      S_WR: begin
        w_en   = wr_fire;
        w_addr = wr_addr;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = (state_q != S_IDLE);
      end
    endcase
  end

`ifdef SRAM_XFER_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              suppressed;

  assign suppressed = ((state_q == S_RD) && !rd_fire) || ((state_q == S_WR) && !wr_fire);

  // Saturating count of access cycles lost to stall or a closed write gate
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
    end else if (suppressed && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_sram_xfer_controller.sv
// Scoreboard bench for sram_xfer_controller: expected access streams queued at start, checked by a monitor.
module tb_sram_xfer_controller;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LEN_MAX = 255;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_DN = 2;

  typedef struct {
    int              kind;
    logic [ADDR_W-1:0] addr;
  } ev_t;

  logic              clk, n_rst, start, wr_gate, stall;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] s_addr, d_addr, len;
  logic              r_en, w_en, busy, done;
  logic [ADDR_W-1:0] r_addr, w_addr;
`ifdef SRAM_XFER_PERF_EN
  logic [15:0]       stall_cycles;
`endif

  sram_xfer_controller #(.ADDR_W(ADDR_W), .LEN_MAX(LEN_MAX)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .mode    (mode),
    .s_addr  (s_addr),
    .d_addr  (d_addr),
    .len     (len),
    .wr_gate (wr_gate),
    .stall   (stall),
    .r_en    (r_en),
    .w_en    (w_en),
    .r_addr  (r_addr),
    .w_addr  (w_addr),
    .busy    (busy),
`ifdef SRAM_XFER_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .done    (done)
  );

  ev_t               q[$];
  ev_t               mon_h;
  bit                mon_ok;
  int                tests = 0;
  int                fails = 0;
  bit                mon_en = 0;
  int                done_seen = 0;
  int                done_cyc = 0;
  int                rd_pops = 0;
  int                exp_stall = 0;
  int                exp_acc = 0;
  int                base_done = 0;
  int                cyc = 0;
  logic [ADDR_W-1:0] exp_r_hold = '0;
  logic [ADDR_W-1:0] exp_w_hold = '0;
  bit                rnd_en = 0;
  int unsigned       stall_pct = 0;
  int unsigned       gate_pct = 0;
  int                stall_at = 0;
  int                gate_low_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle stall / write-gate driver; cyc counts cycles after the start edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc = cyc + 1;
      stall   = (cyc == stall_at) || (rnd_en && ($urandom_range(0, 99) < stall_pct));
      wr_gate = (cyc > gate_low_n) && !(rnd_en && ($urandom_range(0, 99) < gate_pct));
    end
  end

  // Monitor: pops the expected stream whenever the model says an access or done is due
  always @(negedge clk) begin
    if (mon_en) begin
      if ((q.size() != 0) && busy) begin
        mon_h = q[0];
        if (mon_h.kind == K_RD) begin
          chk("rd_en",    32'(r_en),   32'(!stall));
          chk("rd_addr",  32'(r_addr), 32'(mon_h.addr));
          chk("rd_w_en",  32'(w_en),   32'(0));
          chk("rd_whold", 32'(w_addr), 32'(exp_w_hold));
          chk("rd_done",  32'(done),   32'(0));
          if (!stall) begin
            void'(q.pop_front());
            exp_r_hold = mon_h.addr;
            rd_pops++;
          end else begin
            exp_stall++;
          end
        end else if (mon_h.kind == K_WR) begin
          mon_ok = wr_gate && !stall;
          chk("wr_en",    32'(w_en),   32'(mon_ok));
          chk("wr_addr",  32'(w_addr), 32'(mon_h.addr));
          chk("wr_r_en",  32'(r_en),   32'(0));
          chk("wr_rhold", 32'(r_addr), 32'(exp_r_hold));
          chk("wr_done",  32'(done),   32'(0));
          if (mon_ok) begin
            void'(q.pop_front());
            exp_w_hold = mon_h.addr;
          end else begin
            exp_stall++;
          end
        end else begin
          chk("done",      32'(done),   32'(1));
          chk("dn_r_en",   32'(r_en),   32'(0));
          chk("dn_w_en",   32'(w_en),   32'(0));
          chk("dn_rhold",  32'(r_addr), 32'(exp_r_hold));
          chk("dn_whold",  32'(w_addr), 32'(exp_w_hold));
          void'(q.pop_front());
          done_cyc = cyc;
          done_seen++;
        end
      end else begin
        chk("idle_r_en",  32'(r_en),   32'(0));
        chk("idle_w_en",  32'(w_en),   32'(0));
        chk("idle_done",  32'(done),   32'(0));
        chk("idle_rhold", 32'(r_addr), 32'(exp_r_hold));
        chk("idle_whold", 32'(w_addr), 32'(exp_w_hold));
        if (q.size() == 0) chk("idle_busy", 32'(busy), 32'(0));
      end
    end
  end

  // Build the expected stream from the transfer rules and pulse start
  task automatic issue(input logic [1:0] m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                       input logic [ADDR_W-1:0] l, input int sa, input int gl);
    int L;
    ev_t e;
    L = (int'(l) > int'(LEN_MAX)) ? int'(LEN_MAX) : int'(l);
    @(posedge clk);
    #1;
    exp_acc = 0;
    if ((L != 0) && (m != 2'b00)) begin
      if (m[0]) begin
        for (int i = 0; i < L; i++) begin
          e.kind = K_RD;
          e.addr = ADDR_W'(int'(s) + i);
          q.push_back(e);
        end
        exp_acc += L;
      end
      if (m[1]) begin
        for (int i = 0; i < L; i++) begin
          e.kind = K_WR;
          e.addr = ADDR_W'(int'(d) + i);
          q.push_back(e);
        end
        exp_acc += L;
      end
    end
    e.kind = K_DN;
    e.addr = '0;
    q.push_back(e);
    start     = 1'b1;
    mode      = m;
    s_addr    = s;
    d_addr    = d;
    len       = l;
    base_done = done_seen;
    exp_stall = 0;
    @(posedge clk);
    #1;
    start      = 1'b0;
    cyc        = 0;
    stall_at   = sa;
    gate_low_n = gl;
  endtask

  // Wait for done (bounded), optionally throwing ignored start pulses at the busy DUT
  task automatic finish(input bit junk);
    int budget;
    budget = 40 * (exp_acc + 2) + 40;
    for (int k = 0; k < budget; k++) begin
      if (done_seen != base_done) break;
      if (junk) begin
        start  = 1'($urandom_range(0, 1));
        mode   = 2'($urandom_range(0, 3));
        s_addr = ADDR_W'($urandom);
        d_addr = ADDR_W'($urandom);
        len    = ADDR_W'($urandom);
      end
      @(posedge clk);
      #1;
    end
    start      = 1'b0;
    stall_at   = 0;
    gate_low_n = 0;
    chk("done_count", 32'(done_seen - base_done), 32'(1));
    if (done_seen != base_done) begin
      chk("latency", 32'(done_cyc), 32'(exp_acc + exp_stall + 1));
`ifdef SRAM_XFER_PERF_EN
      chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
`endif
    end
  endtask

  task automatic xfer(input logic [1:0] m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                      input logic [ADDR_W-1:0] l, input int sa, input int gl, input bit junk);
    issue(m, s, d, l, sa, gl);
    finish(junk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rd;
    n_rst = 1'b0; start = 1'b0; mode = '0; s_addr = '0; d_addr = '0; len = '0;
    stall = 1'b0; wr_gate = 1'b1;
    #3;
    chk("rst_r_en",   32'(r_en),   32'(0));
    chk("rst_w_en",   32'(w_en),   32'(0));
    chk("rst_busy",   32'(busy),   32'(0));
    chk("rst_done",   32'(done),   32'(0));
    chk("rst_r_addr", 32'(r_addr), 32'(0));
    chk("rst_w_addr", 32'(w_addr), 32'(0));
`ifdef SRAM_XFER_PERF_EN
    chk("rst_stall_cycles", 32'(stall_cycles), 32'(0));
`endif
    @(negedge clk);
    n_rst  = 1'b1;
    mon_en = 1'b1;

    xfer(2'b01, 8'h10, 8'h00, 8'd4, 0, 0, 1'b0);
    xfer(2'b11, 8'hFE, 8'h40, 8'd3, 0, 0, 1'b0);
    xfer(2'b10, 8'h00, 8'h20, 8'd2, 0, 3, 1'b0);
    xfer(2'b01, 8'h00, 8'h00, 8'd3, 2, 0, 1'b0);
    xfer(2'b11, 8'h33, 8'h44, 8'd0, 0, 0, 1'b0);
    xfer(2'b01, 8'h33, 8'h44, 8'd0, 0, 0, 1'b0);
    xfer(2'b00, 8'h12, 8'h34, 8'd5, 0, 0, 1'b0);
    xfer(2'b01, 8'h80, 8'h90, 8'd6, 0, 0, 1'b1);
    xfer(2'b11, 8'hFC, 8'hFD, 8'd5, 0, 0, 1'b1);

    // Abort a read phase after two of five reads
    base_rd = rd_pops;
    issue(2'b01, 8'h30, 8'h00, 8'd5, 0, 0);
    for (int k = 0; k < 40; k++) begin
      if (rd_pops >= base_rd + 2) break;
      @(posedge clk);
      #1;
    end
    chk("abort_reads", 32'(rd_pops - base_rd), 32'(2));
    #2;
    n_rst  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("abort_r_en",   32'(r_en),   32'(0));
    chk("abort_busy",   32'(busy),   32'(0));
    chk("abort_done",   32'(done),   32'(0));
    chk("abort_r_addr", 32'(r_addr), 32'(0));
    chk("abort_w_addr", 32'(w_addr), 32'(0));
    q.delete();
    exp_r_hold = '0;
    exp_w_hold = '0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("abort_no_done", 32'(done_seen), 32'(base_done));
    xfer(2'b01, 8'h55, 8'h00, 8'd1, 0, 0, 1'b0);

    rnd_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [ADDR_W-1:0] l;
      stall_pct = $urandom_range(0, 40);
      gate_pct  = $urandom_range(0, 40);
      l = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(0, 255)) : ADDR_W'($urandom_range(0, 12));
      xfer(2'($urandom_range(0, 3)), ADDR_W'($urandom), ADDR_W'($urandom), l, 0, 0, 1'($urandom_range(0, 1)));
    end
    stall_pct = 20;
    gate_pct  = 20;
    xfer(2'b11, ADDR_W'($urandom), ADDR_W'($urandom), 8'd255, 0, 0, 1'b1);
    rnd_en = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
